aes_round_key_store: RTL and testbench

Buffers the full round-key schedule produced by the key expansion stage and serves it to the AES round engine. It accepts NUM_ROUNDS+1 round keys over a valid/ready stream, in round 0 first order. Once the set is complete, it answers indexed reads with one-cycle latency, in either encrypt order or reversed (decrypt) order. It sits directly downstream of the key expansion stage and upstream of the cipher datapath.

---
 rtl/aes_round_key_store.sv | 143 ++++++++++++++
 tb/tb_aes_round_key_store.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_store.sv
// aes_round_key_store
// Holds the NUM_ROUNDS+1 round keys emitted by key expansion and serves them
// to the cipher datapath with one-cycle indexed reads, in encrypt order or
// reversed (decrypt) order.
//
// Optional feature macro: AES_ROUND_KEY_ZEROIZE_EN
//   When defined, reset and clear first sweep zeros through every entry
//   (one per cycle) before loading is re-enabled, so a discarded schedule
//   never lingers in the storage array.
module aes_round_key_store #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_WIDTH  = 128
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 rk_valid_i,
  output logic                 rk_ready_o,
  input  logic [KEY_WIDTH-1:0] rk_data_i,
  output logic                 keys_ready_o,
  output logic [3:0]           key_count_o,
  input  logic                 rd_en_i,
  input  logic [3:0]           rd_round_i,
  input  logic                 rd_decrypt_i,
  output logic                 rd_valid_o,
  output logic [KEY_WIDTH-1:0] rd_data_o,
  output logic                 rd_err_o
);

  localparam int         NUM_KEYS = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

`ifdef AES_ROUND_KEY_ZEROIZE_EN
  typedef enum logic [1:0] {ST_FILL, ST_FULL, ST_ZERO} state_e;
  localparam state_e RESTART_ST = ST_ZERO;
`else
  typedef enum logic [1:0] {ST_FILL, ST_FULL} state_e;
  localparam state_e RESTART_ST = ST_FILL;
`endif

  state_e                 state_q;
  logic [3:0]             key_count_q;
  logic                   keys_ready_q;
  logic [KEY_WIDTH-1:0]   mem_q [0:NUM_ROUNDS];
  logic                   rd_valid_q;
  logic                   rd_err_q;
  logic [KEY_WIDTH-1:0]   rd_data_q;
`ifdef AES_ROUND_KEY_ZEROIZE_EN
  logic [3:0]             zero_idx_q;
`endif

  logic                   hs;
  logic                   rd_ok_d;
  logic [3:0]             rd_idx_d;

  // clear gates ready so a key offered during clear is never consumed
  assign rk_ready_o = (state_q == ST_FILL) && !clear_i;
  assign hs         = rk_valid_i && rk_ready_o;

  // Read index and acceptance; keys_ready_q already implies the FULL state
  always_comb begin
    rd_idx_d = rd_decrypt_i ? (LAST_IDX - rd_round_i) : rd_round_i;
    rd_ok_d  = rd_en_i && keys_ready_q && (rd_round_i <= LAST_IDX);
  end

  // Control FSM: fill counter, full flag and optional zeroize sweep
  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      state_q      <= RESTART_ST;
      key_count_q  <= 4'd0;
      keys_ready_q <= 1'b0;
`ifdef AES_ROUND_KEY_ZEROIZE_EN
      zero_idx_q   <= 4'd0;
`endif
    end else begin
      case (state_q)
        ST_FILL: begin
          if (hs) begin
            key_count_q <= key_count_q + 4'd1;
            if (key_count_q == LAST_IDX) begin
              state_q      <= ST_FULL;
              keys_ready_q <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          keys_ready_q <= 1'b1;
        end
`ifdef AES_ROUND_KEY_ZEROIZE_EN
        ST_ZERO: begin
          if (zero_idx_q == LAST_IDX) begin
            state_q    <= ST_FILL;
            zero_idx_q <= 4'd0;
          end else begin
            zero_idx_q <= zero_idx_q + 4'd1;
          end
        end
`endif
        default: state_q <= RESTART_ST;
      endcase
    end
  end

  // Key storage: loaded on handshake, wiped one entry per cycle when zeroizing
  always_ff @(posedge clock_i) begin
`ifdef AES_ROUND_KEY_ZEROIZE_EN
    if (state_q == ST_ZERO) begin
      mem_q[zero_idx_q] <= '0;
    end else
`endif
    if (hs && !reset_i) begin
      mem_q[key_count_q] <= rk_data_i;
    end
  end

  // Read port: one-cycle latency; a read in the clear cycle sees old contents
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_ok_d;
      rd_err_q   <= rd_en_i && !rd_ok_d;
      if (rd_ok_d) begin
        rd_data_q <= mem_q[rd_idx_d];
      end else if (rd_en_i) begin
        rd_data_q <= '0;
      end
    end
  end

  assign keys_ready_o = keys_ready_q;
  assign key_count_o  = key_count_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_err_o     = rd_err_q;
  assign rd_data_o    = rd_data_q;

  // NUM_KEYS kept for readability of the storage sizing above
  logic unused_ok;
  assign unused_ok = (NUM_KEYS > 0);

endmodule

// File: tb/tb_aes_round_key_store.sv
// Directed bench for aes_round_key_store using the FIPS-197 AES-128 schedule.
// Build with AES_ROUND_KEY_ZEROIZE_EN defined to also exercise the sweep.
module tb_aes_round_key_store;
  localparam int NR = 10;
  localparam int KW = 128;

  logic          clock = 1'b0;
  logic          reset, clear, rk_valid, rk_ready;
  logic [KW-1:0] rk_data;
  logic          keys_ready;
  logic [3:0]    key_count;
  logic          rd_en, rd_decrypt, rd_valid, rd_err;
  logic [3:0]    rd_round;
  logic [KW-1:0] rd_data;

  int n_vec = 0;
  int n_err = 0;
  logic [KW-1:0] sched [0:NR];

  aes_round_key_store #(.NUM_ROUNDS(NR), .KEY_WIDTH(KW)) dut (
    .clock_i(clock), .reset_i(reset), .clear_i(clear),
    .rk_valid_i(rk_valid), .rk_ready_o(rk_ready), .rk_data_i(rk_data),
    .keys_ready_o(keys_ready), .key_count_o(key_count),
    .rd_en_i(rd_en), .rd_round_i(rd_round), .rd_decrypt_i(rd_decrypt),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic do_read(input logic [3:0] r, input logic dec);
    rd_en = 1'b1; rd_round = r; rd_decrypt = dec;
    tick;
    rd_en = 1'b0;
  endtask

  // Offers keys 0..n-1 with rk_valid held; reports handshakes achieved
  task automatic feed_keys(input int n, output int got);
    int cyc;
    bit hs;
    got = 0; cyc = 0;
    while (got < n && cyc < 100) begin
      rk_valid = 1'b1; rk_data = sched[got];
      #1; hs = rk_ready;
      @(posedge clock); #1;
      if (hs) got++;
      cyc++;
    end
    rk_valid = 1'b0;
  endtask

  // Full schedule load, optionally with random gaps and a clear at clear_at
  task automatic do_fill(input bit gaps, input int clear_at);
    int k, cyc;
    bit cleared, hs;
    k = 0; cyc = 0; cleared = 0;
    while (k < NR+1 && cyc < 300) begin
      rk_data  = sched[k];
      rk_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!cleared && k == clear_at) begin
        rk_valid = 1'b1;
        n_vec++;
        if (key_count !== 4'(k)) begin
          n_err++; $display("FAIL count_before_clear: got %0d expected %0d", key_count, k);
        end
        clear = 1'b1;
      end
      #1;
      hs = rk_valid && rk_ready;
      if (clear) begin
        n_vec++;
        if (rk_ready !== 1'b0) begin
          n_err++; $display("FAIL clear_gates_ready: got %b expected 0", rk_ready);
        end
      end
      if (!gaps && clear_at < 0 && k == NR && rk_ready) begin
        n_vec++;
        if (keys_ready !== 1'b0) begin
          n_err++; $display("FAIL ready_before_last: got %b expected 0", keys_ready);
        end
      end
      @(posedge clock); #1;
      if (clear) begin
        clear = 1'b0; cleared = 1; k = 0;
        n_vec++;
        if (key_count !== 4'd0 || keys_ready !== 1'b0) begin
          n_err++; $display("FAIL clear_drops_count: got cnt=%0d rdy=%b expected cnt=0 rdy=0", key_count, keys_ready);
        end
      end else if (hs) begin
        k++;
      end
      cyc++;
    end
    rk_valid = 1'b0;
    n_vec++;
    if (k != NR+1) begin
      n_err++; $display("FAIL fill_timeout: got %0d keys expected %0d", k, NR+1);
    end
    n_vec++;
    if (keys_ready !== 1'b1 || key_count !== 4'd11 || rk_ready !== 1'b0) begin
      n_err++; $display("FAIL fill_done: got rdy=%b cnt=%0d rk_ready=%b expected 1 11 0", keys_ready, key_count, rk_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    n_vec++;
    if (key_count !== 4'd0 || keys_ready !== 1'b0 || rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_data !== '0) begin
      n_err++; $display("FAIL reset_state: got cnt=%0d rdy=%b v=%b e=%b d=%h expected all 0", key_count, keys_ready, rd_valid, rd_err, rd_data);
    end
    reset = 1'b0;
    tick;
    n_vec++;
`ifdef AES_ROUND_KEY_ZEROIZE_EN
    if (rk_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_rk_ready: got %b expected 0", rk_ready);
    end
`else
    if (rk_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_rk_ready: got %b expected 1", rk_ready);
    end
`endif
  endtask

  task automatic test_partial_reject;
    int got;
    feed_keys(5, got);
    n_vec++;
    if (got != 5 || key_count !== 4'd5) begin
      n_err++; $display("FAIL partial_count: got %0d expected 5", key_count);
    end
    do_read(4'd0, 1'b0);
    n_vec++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
      n_err++; $display("FAIL read_not_full: got e=%b v=%b d=%h expected 1 0 0", rd_err, rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_midload;
    reset = 1'b1; tick; reset = 1'b0;
    n_vec++;
    if (key_count !== 4'd0 || keys_ready !== 1'b0 || rd_err !== 1'b0) begin
      n_err++; $display("FAIL reset_midload: got cnt=%0d rdy=%b e=%b expected 0 0 0", key_count, keys_ready, rd_err);
    end
  endtask

  task automatic test_encrypt_reads;
    logic [3:0] rs [3];
    rs[0] = 4'd0; rs[1] = 4'd10; rs[2] = 4'd5;
    for (int i = 0; i < 3; i++) begin
      do_read(rs[i], 1'b0);
      n_vec++;
      if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== sched[rs[i]]) begin
        n_err++; $display("FAIL enc_read r%0d: got v=%b d=%h expected 1 %h", rs[i], rd_valid, rd_data, sched[rs[i]]);
      end
    end
  endtask

  task automatic test_decrypt_reads;
    do_read(4'd0, 1'b1);
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== sched[10]) begin
      n_err++; $display("FAIL dec_read r0: got %h expected %h", rd_data, sched[10]);
    end
    do_read(4'd10, 1'b1);
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== sched[0]) begin
      n_err++; $display("FAIL dec_read r10: got %h expected %h", rd_data, sched[0]);
    end
  endtask

  task automatic test_back_to_back;
    rd_en = 1'b1; rd_decrypt = 1'b1; rd_round = 4'd0;
    for (int i = 0; i <= NR; i++) begin
      tick;
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== sched[NR-i]) begin
        n_err++; $display("FAIL b2b_read %0d: got v=%b d=%h expected 1 %h", i, rd_valid, rd_data, sched[NR-i]);
      end
      if (i < NR) rd_round = 4'(i + 1);
      else rd_en = 1'b0;
    end
    tick;
    n_vec++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got v=%b expected 0", rd_valid);
    end
  endtask

  task automatic test_reject_full;
    do_read(4'd11, 1'b0);
    n_vec++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
      n_err++; $display("FAIL read_round11: got e=%b v=%b d=%h expected 1 0 0", rd_err, rd_valid, rd_data);
    end
    do_read(4'd2, 1'b0);
    tick;
    n_vec++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_data !== sched[2]) begin
      n_err++; $display("FAIL idle_hold: got v=%b e=%b d=%h expected 0 0 %h", rd_valid, rd_err, rd_data, sched[2]);
    end
  endtask

  task automatic test_clear_with_read;
    rd_en = 1'b1; rd_round = 4'd3; rd_decrypt = 1'b0; clear = 1'b1;
    tick;
    rd_en = 1'b0; clear = 1'b0;
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== sched[3]) begin
      n_err++; $display("FAIL clear_read_data: got v=%b d=%h expected 1 %h", rd_valid, rd_data, sched[3]);
    end
    n_vec++;
    if (keys_ready !== 1'b0 || key_count !== 4'd0) begin
      n_err++; $display("FAIL clear_state: got rdy=%b cnt=%0d expected 0 0", keys_ready, key_count);
    end
    do_read(4'd3, 1'b0);
    n_vec++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL read_after_clear: got e=%b v=%b expected 1 0", rd_err, rd_valid);
    end
    do_fill(1'b0, -1);
  endtask

  task automatic test_gap_clear;
    clear = 1'b1; tick; clear = 1'b0;
    do_fill(1'b1, 6);
    for (int i = 0; i <= NR; i++) begin
      do_read(4'(i), 1'b0);
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== sched[i]) begin
        n_err++; $display("FAIL reload_read r%0d: got %h expected %h", i, rd_data, sched[i]);
      end
    end
  endtask

`ifdef AES_ROUND_KEY_ZEROIZE_EN
  task automatic test_zeroize;
    clear = 1'b1; tick; clear = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      n_vec++;
      if (rk_ready !== 1'b0 || keys_ready !== 1'b0) begin
        n_err++; $display("FAIL zero_sweep cyc%0d: got rk_ready=%b rdy=%b expected 0 0", i, rk_ready, keys_ready);
      end
      tick;
    end
    n_vec++;
    if (rk_ready !== 1'b1) begin
      n_err++; $display("FAIL zero_sweep_end: got %b expected 1", rk_ready);
    end
    for (int i = 0; i <= NR; i++) begin
      n_vec++;
      if (dut.mem_q[i] !== '0) begin
        n_err++; $display("FAIL zero_mem[%0d]: got %h expected 0", i, dut.mem_q[i]);
      end
    end
    clear = 1'b1; tick; clear = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    clear = 1'b1; tick; clear = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      n_vec++;
      if (rk_ready !== 1'b0) begin
        n_err++; $display("FAIL zero_restart cyc%0d: got %b expected 0", i, rk_ready);
      end
      tick;
    end
    n_vec++;
    if (rk_ready !== 1'b1) begin
      n_err++; $display("FAIL zero_restart_end: got %b expected 1", rk_ready);
    end
  endtask
`endif

  initial begin
    sched[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    sched[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    sched[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    sched[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    sched[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    sched[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    sched[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    sched[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    sched[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    sched[9]  = 128'hac7766f319fadc2128d12941575c006e;
    sched[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    reset = 1'b1; clear = 1'b0; rk_valid = 1'b0; rk_data = '0;
    rd_en = 1'b0; rd_round = 4'd0; rd_decrypt = 1'b0;

    test_reset;
    test_partial_reject;
    test_reset_midload;
    do_fill(1'b0, -1);
    test_encrypt_reads;
    test_decrypt_reads;
    test_back_to_back;
    test_reject_full;
    test_clear_with_read;
    test_gap_clear;
`ifdef AES_ROUND_KEY_ZEROIZE_EN
    test_zeroize;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
